param_rom_stream_arbiter: RTL and testbench
===========================================

// Module: param_rom_stream_arbiter
// PURPOSE
// - Shares one parameter ROM read port (2-cycle registered read, 1 word/addr) among NUM_REQ consumer streams.
// - Example: query/key/value bias sources of one encoder layer share a single ROM.
// - Requester i owns words [i*DEPTH, (i+1)*DEPTH); a grant streams that whole region as a valid/ready burst.
// - Replaces a free-running counter with valid tied high: every beat is genuinely valid, and backpressure never drops
//   or duplicates a word.
// PARAMETERS
// - NUM_REQ     3                            number of consumer streams
// - DATA_WIDTH  32                           ROM word width
// - DEPTH       32                           words per requester region (>=1)
// - ROM_LATENCY 2                            cycles from rom_addr to rom_q
// - FIFO_DEPTH  4                            output skid FIFO entries (>= ROM_LATENCY+2)
// - ADDR_WIDTH  $clog2(NUM_REQ*DEPTH)+1      ROM address width
// PORTS
// - clk             in   1                   single clock, rising edge
// - rst             in   1                   synchronous, active-high reset
// - req             in   NUM_REQ             level request per stream; sampled only in IDLE
// - rom_addr        out  ADDR_WIDTH          ROM address0
// - rom_ce          out  1                   ROM ce0
// - rom_q           in   DATA_WIDTH          ROM q0
// - data_out        out  DATA_WIDTH          FIFO head word (shared bus)
// - data_out_valid  out  NUM_REQ             one-hot valid, granted stream only
// - data_out_ready  in   NUM_REQ             per-stream ready
// - data_out_last   out  1                   head word is final word of burst
// - busy            out  1                   state != IDLE
// BEHAVIOUR
// - Reset values: all outputs 0; state IDLE; rr_ptr=0; FIFO empty; in-flight pipe cleared.
// - Reset mid-burst aborts the burst. Words in flight are discarded and no valid is asserted until a new grant.
// - rom_ce=1 whenever not in reset. The ROM pipeline advances freely; a parallel ROM_LATENCY-deep tag shift register
//   marks which rom_q cycles carry issued words.
// - FSM IDLE -> ISSUE -> DRAIN -> IDLE.
// - IDLE, any req bit set:
//   - grant = first set bit searching rr_ptr, rr_ptr+1, ... (mod NUM_REQ).
//   - Register grant, set addr_cnt=0, go to ISSUE.
// - ISSUE: issue when fifo_count + inflight < FIFO_DEPTH.
//   - Drive rom_addr = grant*DEPTH + addr_cnt; tag enters pipe; addr_cnt++.
//   - At addr_cnt==DEPTH-1 issued, go to DRAIN.
//   - If no issue this cycle, rom_addr holds its last value.
// - DRAIN: wait until inflight==0 and FIFO empty.
//   - Then rr_ptr = (grant+1) mod NUM_REQ; go to IDLE.
// - req changes after a grant are ignored; the burst always completes DEPTH words.
// - Tagged rom_q is written to the FIFO ROM_LATENCY cycles after issue.
// - Credit guarantees the FIFO never overflows. Push and pop in the same cycle leave the count unchanged.
// - data_out_valid[grant] = FIFO non-empty. Pop when data_out_valid[grant] & data_out_ready[grant].
// - Ready on ungranted streams has no effect.
// - data_out_last is set on the entry tagged addr_cnt==DEPTH-1.
// - Latency:
//   - req sampled in cycle t gives grant and first rom_addr in t+1.
//   - First data_out_valid appears in t+1+ROM_LATENCY+1 (t+4 at defaults).
// - Throughput: 1 word/cycle with ready held high. Burst length DEPTH + ROM_LATENCY + 2 cycles including IDLE.
// - Wrap: address offset never exceeds DEPTH-1; no carry into the next region.
// - DEPTH=1: ISSUE lasts one cycle; the word carries data_out_last.
// STRUCTURE
// - Package param_src_pkg: state enum {IDLE, ISSUE, DRAIN}, ROM_LATENCY default, rr_pick() function.
// - Sub-module param_stream_skid_fifo:
//   - Parameters DATA_WIDTH+1 and FIFO_DEPTH; carries data plus the last flag.
//   - Show-ahead; count output feeds the credit check.
// - Top holds the FSM, round-robin pointer, address counter and tag pipe.
// TESTING
// - Reset hold then release, req=0:
//   - All outputs 0, busy=0 indefinitely.
//   - rom_ce=1 from the first post-reset cycle.
// - req=3'b001 held, ready=1 (ROM word k holds k):
//   - Stream 0 receives 0..31 on consecutive cycles from t+4.
//   - last on word 31; busy drops after drain.
// - req=3'b111 held, ready=1:
//   - Grants 0,1,2,0 in order.
//   - Stream 1 receives 32..63, stream 2 receives 64..95.
//   - Only one valid bit high at a time.
// - Stream 0 burst, ready toggled 1,0,0,1 randomly:
//   - Every word 0..31 appears exactly once, in order.
//   - fifo_count never exceeds 4.
//   - rom_addr stalls while credit is exhausted.
// - rst pulsed at word 10 of a stream 1 burst:
//   - Outputs zero next cycle; FIFO empty; rr_ptr=0.
//   - With req=3'b010 the new burst restarts at word 32.
// - DEPTH=1, NUM_REQ=2, req=2'b11:
//   - Alternating single-word bursts, each with last=1.
//   - Stream 0 gets word 0, stream 1 gets word 1.

Source files
------------

// File: rtl/param_rom_stream_arbiter_pkg.sv
// Shared types and helpers for the parameter-ROM stream arbiter.
package param_src_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int unsigned DEF_ROM_LATENCY = 2;
  localparam int          MAX_REQ         = 16;

  // One entry of the in-flight tag pipe that shadows the ROM read pipeline.
  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

  // Round-robin pick: first set bit searching ptr, ptr+1, ... modulo n.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] req, input int ptr, input int n);
    int pick;
    int idx;
    pick = ptr;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (req[4'(idx)]) pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/param_rom_stream_arbiter_if.sv
// Shared output stream bus: one data word, per-stream valid/ready, last flag.
interface param_rom_stream_arbiter_if #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data_out;
  logic [NUM_REQ-1:0]    data_out_valid;
  logic [NUM_REQ-1:0]    data_out_ready;
  logic                  data_out_last;

  modport master (output data_out, data_out_valid, data_out_last, input data_out_ready);
  modport slave  (input data_out, data_out_valid, data_out_last, output data_out_ready);
endinterface

// File: rtl/param_rom_stream_arbiter_fifo.sv
// Show-ahead skid FIFO holding ROM words plus their last flag.
module param_stream_skid_fifo #(
  parameter int unsigned WIDTH      = 33,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_push,
  input  logic [WIDTH-1:0]                i_data,
  input  logic                            i_pop,
  output logic [WIDTH-1:0]                o_data,
  output logic                            o_empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] o_count
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Storage write; contents need no reset since the count gates visibility.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and occupancy bookkeeping; simultaneous push/pop keeps the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
endmodule

// File: rtl/param_rom_stream_arbiter.sv
// Round-robin arbiter streaming per-requester regions of one shared parameter ROM.
module param_rom_stream_arbiter
  import param_src_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 3,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned ROM_LATENCY = DEF_ROM_LATENCY,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ADDR_WIDTH  = $clog2(NUM_REQ * DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          i_req,
  output logic [ADDR_WIDTH-1:0]       o_rom_addr,
  output logic                        o_rom_ce,
  input  logic [DATA_WIDTH-1:0]       i_rom_q,
  param_rom_stream_arbiter_if.master  o_stream,
  output logic                        o_busy
);
  localparam int unsigned GNT_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W  = $clog2(FIFO_DEPTH + ROM_LATENCY + 2) + 1;

  state_e                r_state, w_state_nxt;
  logic [GNT_W-1:0]      r_grant, r_rr_ptr, w_pick;
  logic [CNT_W-1:0]      r_addr_cnt;
  logic [ADDR_WIDTH-1:0] r_rom_addr, w_base;
  logic                  r_rom_ce, r_issue, r_issue_last;
  tag_t                  r_tag [ROM_LATENCY];
  logic [FCNT_W-1:0]     w_fifo_count;
  logic                  w_fifo_empty, w_push, w_pop;
  logic [DATA_WIDTH:0]   w_fifo_head;
  logic [NUM_REQ-1:0]    w_gnt_oh;
  logic [OCC_W-1:0]      w_occ;
  logic                  w_credit, w_drained, w_start, w_sched, w_rr_adv;

  assign w_pick   = GNT_W'(rr_pick(MAX_REQ'(i_req), int'(r_rr_ptr), int'(NUM_REQ)));
  assign w_base   = ADDR_WIDTH'(r_grant) * ADDR_WIDTH'(DEPTH);
  assign w_gnt_oh = NUM_REQ'(1) << r_grant;
  assign w_push   = r_tag[ROM_LATENCY-1].valid;
  assign w_pop    = !w_fifo_empty && |(o_stream.data_out_ready & w_gnt_oh);

  // Words owed to the FIFO: stored, in the ROM pipe, or presented this cycle.
  always_comb begin
    w_occ = OCC_W'(w_fifo_count) + OCC_W'(r_issue);
    for (int unsigned i = 0; i < ROM_LATENCY; i++) w_occ = w_occ + OCC_W'(r_tag[i].valid);
    w_credit  = (w_occ - OCC_W'(w_pop)) < OCC_W'(FIFO_DEPTH);
    w_drained = (w_occ - OCC_W'(w_pop)) == '0;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and per-cycle control decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_sched     = 1'b0;
    w_rr_adv    = 1'b0;
    case (r_state)
      IDLE: begin
        if (|i_req) begin
          w_start     = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (r_issue && r_issue_last) w_state_nxt = DRAIN;
        else                         w_sched     = w_credit;
      end
      DRAIN: begin
        if (w_drained) begin
          w_rr_adv    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Address issue, grant capture, round-robin pointer and ROM tag pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant      <= '0;
      r_rr_ptr     <= '0;
      r_addr_cnt   <= '0;
      r_rom_addr   <= '0;
      r_rom_ce     <= 1'b0;
      r_issue      <= 1'b0;
      r_issue_last <= 1'b0;
      for (int unsigned i = 0; i < ROM_LATENCY; i++) r_tag[i] <= '0;
    end else begin
      r_rom_ce <= 1'b1;
      r_tag[0] <= '{valid: r_issue, last: r_issue_last};
      for (int unsigned i = 1; i < ROM_LATENCY; i++) r_tag[i] <= r_tag[i-1];
      r_issue <= 1'b0;
      if (w_start) begin
        r_grant      <= w_pick;
        r_rom_addr   <= ADDR_WIDTH'(w_pick) * ADDR_WIDTH'(DEPTH);
        r_addr_cnt   <= CNT_W'(1);
        r_issue      <= 1'b1;
        r_issue_last <= (DEPTH == 1);
      end else if (w_sched) begin
        r_rom_addr   <= w_base + ADDR_WIDTH'(r_addr_cnt);
        r_addr_cnt   <= r_addr_cnt + CNT_W'(1);
        r_issue      <= 1'b1;
        r_issue_last <= (r_addr_cnt == CNT_W'(DEPTH - 1));
      end
      if (w_rr_adv) r_rr_ptr <= (r_grant == GNT_W'(NUM_REQ - 1)) ? '0 : r_grant + GNT_W'(1);
    end
  end

  param_stream_skid_fifo #(
    .WIDTH      (DATA_WIDTH + 1),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  ({r_tag[ROM_LATENCY-1].last, i_rom_q}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_head),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign o_rom_addr              = r_rom_addr;
  assign o_rom_ce                = r_rom_ce;
  assign o_busy                  = (r_state != IDLE);
  assign o_stream.data_out_valid = w_fifo_empty ? '0 : w_gnt_oh;
  assign o_stream.data_out       = w_fifo_empty ? '0 : w_fifo_head[DATA_WIDTH-1:0];
  assign o_stream.data_out_last  = !w_fifo_empty && w_fifo_head[DATA_WIDTH];
endmodule

// File: tb/tb_param_rom_stream_arbiter.sv
// Bench for param_rom_stream_arbiter: scoreboard of expected beats plus a vector table.
`timescale 1ns/1ps
module tb_param_rom_stream_arbiter;
  localparam int unsigned NR  = 3;
  localparam int unsigned DW  = 32;
  localparam int unsigned DP  = 32;
  localparam int unsigned LAT = 2;
  localparam int unsigned FD  = 4;
  localparam int unsigned AW  = $clog2(NR * DP) + 1;
  localparam int unsigned NR2 = 2;
  localparam int unsigned DP2 = 1;
  localparam int unsigned AW2 = $clog2(NR2 * DP2) + 1;

  typedef struct {
    int          stream;
    logic [DW-1:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    logic [NR-1:0] req;
    bit            rnd;
    int            nb;
    int            g[4];
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1;
  logic [NR-1:0]  req = '0;
  logic [NR-1:0]  ready = '1;
  bit             rnd_ready = 1'b0;
  logic [AW-1:0]  rom_addr;
  logic           rom_ce, busy;
  logic [DW-1:0]  rom_q = '0, rom_s1 = '0;

  logic [NR2-1:0] req2 = '0;
  logic [AW2-1:0] rom2_addr;
  logic           rom2_ce, busy2;
  logic [DW-1:0]  rom2_q = '0, rom2_s1 = '0;

  param_rom_stream_arbiter_if #(.NUM_REQ(NR),  .DATA_WIDTH(DW)) sif ();
  param_rom_stream_arbiter_if #(.NUM_REQ(NR2), .DATA_WIDTH(DW)) sif2 ();
  assign sif.data_out_ready  = ready;
  assign sif2.data_out_ready = '1;

  param_rom_stream_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .DEPTH(DP), .ROM_LATENCY(LAT), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .i_req(req), .o_rom_addr(rom_addr), .o_rom_ce(rom_ce),
    .i_rom_q(rom_q), .o_stream(sif), .o_busy(busy));

  param_rom_stream_arbiter #(.NUM_REQ(NR2), .DATA_WIDTH(DW), .DEPTH(DP2), .ROM_LATENCY(LAT), .FIFO_DEPTH(FD)) dut2 (
    .clk(clk), .rst(rst), .i_req(req2), .o_rom_addr(rom2_addr), .o_rom_ce(rom2_ce),
    .i_rom_q(rom2_q), .o_stream(sif2), .o_busy(busy2));

  // ROM models: word k holds k, two register stages.
  always @(posedge clk) if (rom_ce)  begin rom_s1  <= DW'(rom_addr);  rom_q  <= rom_s1;  end
  always @(posedge clk) if (rom2_ce) begin rom2_s1 <= DW'(rom2_addr); rom2_q <= rom2_s1; end

  int    n_cmp = 0;
  int    n_bad = 0;
  int    n_xfer = 0;
  beat_t sbq[$];
  beat_t got2[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int oh_idx(input logic [NR-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < int'(NR); i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_burst(input int g);
    for (int w = 0; w < int'(DP); w++)
      sbq.push_back('{stream: g, data: DW'(g * int'(DP) + w), last: (w == int'(DP) - 1)});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    req2 = '0;
    repeat (3) tick();
    sbq.delete();
    got2.delete();
    n_xfer = 0;
    rst = 1'b0;
  endtask

  task automatic wait_busy(input logic val, input int budget);
    int k;
    k = 0;
    while (busy !== val && k < budget) begin
      tick();
      k++;
    end
    if (busy !== val) check("busy_wait_timeout", longint'(busy), longint'(val));
  endtask

  // Ready driver: all-ones or random per cycle, updated just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      ready = rnd_ready ? NR'($urandom) : '1;
    end
  end

  // Monitor for the main DUT: one-hot valid, FIFO bound, scoreboard compare.
  always @(negedge clk) begin
    beat_t e;
    check("valid_onehot", longint'($countones(sif.data_out_valid) <= 1), 1);
    check("fifo_count_bound", longint'(dut.w_fifo_count <= 3'(FD)), 1);
    if (!rst && |(sif.data_out_valid & sif.data_out_ready)) begin
      if (sbq.size() == 0) begin
        check("unexpected_beat", longint'(sif.data_out), -1);
      end else begin
        e = sbq.pop_front();
        check("beat_stream", longint'(oh_idx(sif.data_out_valid)), longint'(e.stream));
        check("beat_data", longint'(sif.data_out), longint'(e.data));
        check("beat_last", longint'(sif.data_out_last), longint'(e.last));
      end
      n_xfer++;
    end
  end

  // Monitor for the DEPTH=1 instance: collect accepted beats.
  always @(negedge clk) begin
    if (!rst && |(sif2.data_out_valid & sif2.data_out_ready)) begin
      got2.push_back('{stream: (sif2.data_out_valid[1] ? 1 : 0), data: sif2.data_out, last: sif2.data_out_last});
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  vec_t vecs[6];

  initial begin
    int k, first, nbusy;
    beat_t exp2[4];

    vecs[0] = '{req: 3'b001, rnd: 1'b0, nb: 1, g: '{0, 0, 0, 0}};
    vecs[1] = '{req: 3'b111, rnd: 1'b0, nb: 4, g: '{0, 1, 2, 0}};
    vecs[2] = '{req: 3'b001, rnd: 1'b1, nb: 1, g: '{0, 0, 0, 0}};
    vecs[3] = '{req: 3'b110, rnd: 1'b0, nb: 2, g: '{1, 2, 0, 0}};
    vecs[4] = '{req: 3'b101, rnd: 1'b1, nb: 2, g: '{0, 2, 0, 0}};
    vecs[5] = '{req: 3'b100, rnd: 1'b0, nb: 1, g: '{2, 0, 0, 0}};

    // Reset and idle behaviour with no requests.
    do_reset();
    tick();
    check("rom_ce_after_reset", longint'(rom_ce), 1);
    check("rr_ptr_reset", longint'(dut.r_rr_ptr), 0);
    for (int i = 0; i < 8; i++) begin
      check("idle_busy", longint'(busy), 0);
      check("idle_valid", longint'(sif.data_out_valid), 0);
      check("idle_data", longint'(sif.data_out), 0);
      check("idle_last", longint'(sif.data_out_last), 0);
      check("idle_addr", longint'(rom_addr), 0);
      tick();
    end

    // Latency and burst length for a single stream-0 burst.
    do_reset();
    tick();
    push_burst(0);
    req = 3'b001;
    tick();
    k = 1;
    check("first_addr", longint'(rom_addr), 0);
    check("busy_after_grant", longint'(busy), 1);
    req = '0;
    first = 0;
    nbusy = busy ? 1 : 0;
    while (busy && k < 200) begin
      tick();
      k++;
      if (first == 0 && sif.data_out_valid != '0) first = k;
      if (busy) nbusy++;
    end
    check("first_valid_cycle", longint'(first), 4);
    check("burst_busy_cycles", longint'(nbusy), longint'(DP + LAT + 1));
    check("burst_beats", longint'(n_xfer), longint'(DP));
    check("burst_sb_empty", longint'(sbq.size()), 0);

    // Vector table: request pattern, ready mode, expected grant order.
    foreach (vecs[v]) begin
      do_reset();
      rnd_ready = vecs[v].rnd;
      for (int b = 0; b < vecs[v].nb; b++) push_burst(vecs[v].g[b]);
      req = vecs[v].req;
      for (int b = 0; b < vecs[v].nb; b++) begin
        wait_busy(1'b1, 100);
        if (b == vecs[v].nb - 1) req = '0;
        wait_busy(1'b0, 2000);
      end
      rnd_ready = 1'b0;
      check("vec_beats", longint'(n_xfer), longint'(vecs[v].nb * int'(DP)));
      check("vec_sb_empty", longint'(sbq.size()), 0);
    end

    // Reset at word 10 of a stream-1 burst, then a clean restart.
    do_reset();
    push_burst(1);
    req = 3'b010;
    k = 0;
    while (n_xfer < 10 && k < 200) begin
      tick();
      k++;
    end
    check("reached_word10", longint'(n_xfer), 10);
    rst = 1'b1;
    req = '0;
    sbq.delete();
    tick();
    check("rst_valid", longint'(sif.data_out_valid), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_data", longint'(sif.data_out), 0);
    check("rst_last", longint'(sif.data_out_last), 0);
    check("rst_fifo_count", longint'(dut.w_fifo_count), 0);
    check("rst_rr_ptr", longint'(dut.r_rr_ptr), 0);
    rst = 1'b0;
    n_xfer = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_quiet", longint'(sif.data_out_valid), 0);
    end
    push_burst(1);
    req = 3'b010;
    wait_busy(1'b1, 100);
    req = '0;
    wait_busy(1'b0, 2000);
    check("restart_beats", longint'(n_xfer), longint'(DP));
    check("restart_sb_empty", longint'(sbq.size()), 0);

    // DEPTH=1, two requesters both asserted: alternating single-word bursts.
    do_reset();
    req2 = 2'b11;
    k = 0;
    while (got2.size() < 4 && k < 200) begin
      tick();
      k++;
    end
    req2 = '0;
    check("d1_beat_count", longint'(got2.size() >= 4), 1);
    exp2[0] = '{stream: 0, data: 0, last: 1'b1};
    exp2[1] = '{stream: 1, data: 1, last: 1'b1};
    exp2[2] = '{stream: 0, data: 0, last: 1'b1};
    exp2[3] = '{stream: 1, data: 1, last: 1'b1};
    for (int i = 0; i < 4; i++) begin
      if (i < got2.size()) begin
        check("d1_stream", longint'(got2[i].stream), longint'(exp2[i].stream));
        check("d1_data", longint'(got2[i].data), longint'(exp2[i].data));
        check("d1_last", longint'(got2[i].last), longint'(exp2[i].last));
      end
    end
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
